pulse_capture_hold: RTL and testbench
=====================================

Name: pulse_capture_hold

Overview:
- Receiving end of the one-cycle pulse convention used in the exception/interrupt pipeline.
- A producer drives data_i to IDLE_VALUE when idle. It drives any other value for exactly one cycle to signal an event, such as a trap cause or interrupt vector.
- This block detects each non-idle value, queues it, and holds it stable on data_o until the consumer (the trap/CSR unit) acknowledges it.
- Events arriving while the consumer is stalled are therefore never missed silently.

Parameters:
- WIDTH, 8, event payload width.
- IDLE_VALUE, {WIDTH{1'b0}}, input value meaning "no event"; also driven on data_o when the queue is empty.
- DEPTH, 4, queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  WIDTH  pulse stream; a value != IDLE_VALUE is one event per cycle.
- ack_i  input  1  consumer takes the head entry this cycle; ignored when valid_o=0.
- flush_i  input  1  synchronous discard of all queued events (pipeline flush).
- clr_ovf_i  input  1  clears overflow_o.
- valid_o  output  1  head entry present.
- data_o  output  WIDTH  head entry; IDLE_VALUE when valid_o=0.
- count_o  output  PTR_W+1  number of queued entries, 0..DEPTH.
- overflow_o  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (async, rst_n=0): read pointer, write pointer and count go to 0; valid_o=0; data_o=IDLE_VALUE; count_o=0; overflow_o=0. Storage contents are don't-care.
- Push condition: data_i != IDLE_VALUE. Each cycle with a non-idle value is a distinct event. Back-to-back identical values push twice.
- Pop condition: ack_i && valid_o.
- Latency: a push into an empty queue at cycle N gives valid_o=1 with data_o = that value from cycle N+1. Outputs are registered state; there is no combinational path from data_i to data_o.
- Order: strict FIFO. data_o is the head and stays constant until popped.
- Push with no pop, count<DEPTH: write at wr_ptr, wr_ptr+1, count+1.
- Pop with no push: rd_ptr+1, count-1.
- Push and pop in the same cycle, count>=1: both happen and count is unchanged. This holds at count=DEPTH too: the new event is accepted.
- Push when count=0 and ack_i=1: ack_i is ignored because valid_o=0. The event is accepted and count becomes 1.
- Full with push and no pop: the event is dropped, storage is unchanged, and overflow_o is set to 1 next cycle.
- Pointer wrap-around: pointers wrap modulo DEPTH. count, not the pointers, distinguishes full from empty.
- flush_i=1 has priority over push and pop. Next cycle rd_ptr=wr_ptr=0, count=0, valid_o=0, and any same-cycle data_i event is discarded. Flush also clears overflow_o.
- clr_ovf_i=1: overflow_o=0 next cycle. If a drop occurs in the same cycle, the set wins and overflow_o=1.
- Reset mid-operation clears everything immediately, without waiting for a clock edge.
- Widths: count_o has PTR_W+1 bits so that DEPTH is representable. There is no arithmetic on the payload.

Decomposition:
- TRUE/FALSE come from the shared core defines header, already in use.
- No new typedefs are needed. IDLE_VALUE remains a parameter so each instance matches its producer's idle encoding.
- One sub-module is natural: pulse_fifo_mem, a DEPTH×WIDTH register array with one write port and one asynchronous read port, and no reset on storage.
- Pointer, count and flag control stay in the top module.

Test Plan:
- Single event: WIDTH=8, DEPTH=4. Drive data_i=8'h0B for one cycle at N, ack_i=0. Expect valid_o=1, data_o=8'h0B, count_o=1 from N+1, held indefinitely. Then ack_i=1 for one cycle, giving valid_o=0, data_o=8'h00 and count_o=0 the following cycle.
- Ordered burst with overflow: drive 8'h01..8'h05 on consecutive cycles with ack_i=0. Expect count_o=4 and overflow_o=1 after the 5th. Draining with ack_i held high yields 01, 02, 03, 04, then valid_o=0; 05 never appears.
- Full plus simultaneous push and pop: fill with 11, 22, 33, 44. In one cycle drive data_i=8'h55 with ack_i=1. Expect count_o stays 4, overflow_o stays 0, and the drain order is 22, 33, 44, 55. Repeat for more than 8 cycles to check pointer wrap.
- Empty push with ack: queue empty, data_i=8'h07, ack_i=1 in the same cycle. Expect valid_o=1, data_o=8'h07, count_o=1 next cycle.
- Flush priority: queue holds 2 entries and overflow_o=1. Assert flush_i, ack_i and data_i=8'h09 together. Expect valid_o=0, count_o=0, overflow_o=0 next cycle, and no 8'h09 afterwards.
- Async reset: with 3 entries queued, pulse rst_n low between clock edges. Expect valid_o=0, data_o=IDLE_VALUE and count_o=0 immediately, before the next clk edge. Re-run with IDLE_VALUE=8'hFF to confirm that 8'h00 input is treated as an event.

Source files
------------

// File: rtl/pulse_capture_hold_pkg.sv
// rtl/pulse_capture_hold_pkg.sv - shared constants for the pulse capture/hold block
package pulse_capture_hold_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/pulse_capture_hold_if.sv
// rtl/pulse_capture_hold_if.sv - event producer/consumer bundle for pulse_capture_hold
interface pulse_capture_hold_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
);

  logic [WIDTH-1:0] data_i;
  logic             ack_i;
  logic             flush_i;
  logic             clr_ovf_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [PTR_W:0]   count_o;
  logic             overflow_o;

  // Producer/consumer side: drives the pulse stream and the acknowledges.
  modport master (
    output data_i, ack_i, flush_i, clr_ovf_i,
    input  valid_o, data_o, count_o, overflow_o
  );

  // Capture block side.
  modport slave (
    input  data_i, ack_i, flush_i, clr_ovf_i,
    output valid_o, data_o, count_o, overflow_o
  );

endinterface

// File: rtl/pulse_fifo_mem.sv
// rtl/pulse_fifo_mem.sv - event storage array, one write port and one asynchronous read port
module pulse_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; validity is tracked by the controller's count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pulse_capture_hold.sv
// rtl/pulse_capture_hold.sv - captures one-cycle event pulses into a FIFO and holds the head until acked
module pulse_capture_hold
  import pulse_capture_hold_pkg::*;
#(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}},
  parameter int              DEPTH      = 4
) (
  input  logic clk,
  input  logic rst_n,
  pulse_capture_hold_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic [WIDTH-1:0] head;

  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // Decode this cycle's push/pop; a full queue still accepts when the head leaves in the same cycle.
  always_comb begin
    push  = (bus.data_i != IDLE_VALUE);
    pop   = bus.ack_i && (count != '0);
    wr_en = 1'b0;
    drop  = 1'b0;
    if (!bus.flush_i && push) begin
      if ((count != FULL_COUNT) || pop) begin
        wr_en = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Pointer, occupancy and sticky overflow control; flush outranks every other request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= FALSE;
    end else if (bus.flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= FALSE;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (!wr_en && pop) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= TRUE;
      end else if (bus.clr_ovf_i) begin
        overflow <= FALSE;
      end
    end
  end

  pulse_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_i),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign bus.valid_o    = (count != '0);
  assign bus.data_o     = (count != '0) ? head : IDLE_VALUE;
  assign bus.count_o    = count;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_pulse_capture_hold.sv
// tb/tb_pulse_capture_hold.sv - self-checking bench for pulse_capture_hold
module tb_pulse_capture_hold;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  pulse_capture_hold_if #(.WIDTH(8), .DEPTH(DEPTH)) a_if ();
  pulse_capture_hold_if #(.WIDTH(8), .DEPTH(DEPTH)) b_if ();

  pulse_capture_hold #(.WIDTH(8), .IDLE_VALUE(8'h00), .DEPTH(DEPTH)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  pulse_capture_hold #(.WIDTH(8), .IDLE_VALUE(8'hFF), .DEPTH(DEPTH)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference queue for instance A (idle value 8'h00).
  logic [7:0] q[$];
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Queue semantics: the head may leave, then the new event joins if room remains.
  task automatic model_step();
    logic popped;
    logic dropped;
    if (a_if.flush_i) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      popped  = a_if.ack_i && (q.size() > 0);
      dropped = 1'b0;
      if (popped) void'(q.pop_front());
      if (a_if.data_i != 8'h00) begin
        if (q.size() < DEPTH) q.push_back(a_if.data_i);
        else dropped = 1'b1;
      end
      if (a_if.clr_ovf_i) m_ovf = 1'b0;
      if (dropped) m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : 8'h00;
    check("valid", 32'(a_if.valid_o), 32'(q.size() > 0));
    check("data", 32'(a_if.data_o), 32'(exp_data));
    check("count", 32'(a_if.count_o), q.size());
    check("overflow", 32'(a_if.overflow_o), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycle(input logic [7:0] d, input logic ack, input logic flush, input logic clr);
    a_if.data_i    = d;
    a_if.ack_i     = ack;
    a_if.flush_i   = flush;
    a_if.clr_ovf_i = clr;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_ovf    = 1'b0;
    a_if.data_i = 8'h00; a_if.ack_i = 1'b0; a_if.flush_i = 1'b0; a_if.clr_ovf_i = 1'b0;
    b_if.data_i = 8'hFF; b_if.ack_i = 1'b0; b_if.flush_i = 1'b0; b_if.clr_ovf_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(a_if.valid_o), 0);
    check("reset_count", 32'(a_if.count_o), 0);
    check("reset_data", 32'(a_if.data_o), 0);
    check("reset_ovf", 32'(a_if.overflow_o), 0);
    check("reset_b_data", 32'(b_if.data_o), 32'hFF);
    rst_n = 1'b1;

    // Single event held until acknowledged.
    cycle(8'h0B, 0, 0, 0);
    check("single_valid", 32'(a_if.valid_o), 1);
    check("single_data", 32'(a_if.data_o), 32'h0B);
    check("single_count", 32'(a_if.count_o), 1);
    repeat (3) cycle(8'h00, 0, 0, 0);
    check("single_hold", 32'(a_if.data_o), 32'h0B);
    cycle(8'h00, 1, 0, 0);
    check("single_pop_valid", 32'(a_if.valid_o), 0);
    check("single_pop_data", 32'(a_if.data_o), 0);

    // Ordered burst with overflow; 05 is dropped.
    for (int i = 1; i <= 5; i++) cycle(8'(i), 0, 0, 0);
    check("burst_count", 32'(a_if.count_o), 4);
    check("burst_ovf", 32'(a_if.overflow_o), 1);
    for (int i = 1; i <= 4; i++) begin
      check("burst_order", 32'(a_if.data_o), i);
      cycle(8'h00, 1, 0, 0);
    end
    check("burst_empty", 32'(a_if.valid_o), 0);
    cycle(8'h00, 0, 0, 1);
    check("clr_ovf", 32'(a_if.overflow_o), 0);

    // Full queue with simultaneous push and pop, then pointer wrap.
    cycle(8'h11, 0, 0, 0); cycle(8'h22, 0, 0, 0);
    cycle(8'h33, 0, 0, 0); cycle(8'h44, 0, 0, 0);
    cycle(8'h55, 1, 0, 0);
    check("full_pp_count", 32'(a_if.count_o), 4);
    check("full_pp_ovf", 32'(a_if.overflow_o), 0);
    check("full_pp_head", 32'(a_if.data_o), 32'h22);
    for (int i = 0; i < 10; i++) cycle(8'(8'h60 + i), 1, 0, 0);
    check("wrap_head", 32'(a_if.data_o), 32'h66);
    repeat (4) cycle(8'h00, 1, 0, 0);

    // Push into empty queue with ack asserted.
    cycle(8'h07, 1, 0, 0);
    check("empty_ack_valid", 32'(a_if.valid_o), 1);
    check("empty_ack_data", 32'(a_if.data_o), 32'h07);
    check("empty_ack_count", 32'(a_if.count_o), 1);
    cycle(8'h00, 1, 0, 0);

    // Flush priority over push, pop and overflow.
    for (int i = 1; i <= 5; i++) cycle(8'(8'hA0 + i), 0, 0, 0);
    cycle(8'h00, 1, 0, 0); cycle(8'h00, 1, 0, 0);
    check("pre_flush_count", 32'(a_if.count_o), 2);
    cycle(8'h09, 1, 1, 0);
    check("flush_valid", 32'(a_if.valid_o), 0);
    check("flush_count", 32'(a_if.count_o), 0);
    check("flush_ovf", 32'(a_if.overflow_o), 0);
    repeat (2) cycle(8'h00, 0, 0, 0);

    // Drop and clear in the same cycle: set wins.
    for (int i = 1; i <= 4; i++) cycle(8'(8'hB0 + i), 0, 0, 0);
    cycle(8'h5A, 0, 0, 1);
    check("drop_vs_clr", 32'(a_if.overflow_o), 1);
    cycle(8'h00, 0, 0, 1);
    check("clr_after", 32'(a_if.overflow_o), 0);

    // Instance B treats 8'h00 as an event and 8'hFF as idle.
    b_if.data_i = 8'h00;
    cycle(8'h00, 1, 0, 0);
    b_if.data_i = 8'hFF;
    check("b_zero_valid", 32'(b_if.valid_o), 1);
    check("b_zero_data", 32'(b_if.data_o), 0);
    check("b_zero_count", 32'(b_if.count_o), 1);
    b_if.data_i = 8'h00;
    cycle(8'h00, 0, 0, 0); cycle(8'h00, 0, 0, 0);
    b_if.data_i = 8'hFF;
    cycle(8'h00, 0, 0, 0);
    check("b_count3", 32'(b_if.count_o), 3);

    // Asynchronous reset between edges with 3 entries queued.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(a_if.valid_o), 0);
    check("async_data", 32'(a_if.data_o), 0);
    check("async_count", 32'(a_if.count_o), 0);
    check("async_b_valid", 32'(b_if.valid_o), 0);
    check("async_b_data", 32'(b_if.data_o), 32'hFF);
    check("async_b_count", 32'(b_if.count_o), 0);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h3C, 0, 0, 0);
    check("post_reset_data", 32'(a_if.data_o), 32'h3C);
    cycle(8'h00, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
